velocity_ramp_ctrl: RTL and testbench

//  Parametrised 2-axis velocity controller for the snake game. Debounces the raw
//  U/D/L/R buttons, generates its own velocity-update tick, and ramps signed X/Y

---
 rtl/velocity_ramp_ctrl.sv | 164 ++++++++++++++++
 tb/tb_velocity_ramp_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/velocity_ramp_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : velocity_ramp_ctrl
// Description : Debounced 4-button, 2-axis signed velocity ramp/snap controller
//               with an internal velocity-update tick.
// Revision    : 1.0 - initial release
// ============================================================================
module velocity_ramp_ctrl #(
    parameter int VEL_W      = 13,
    parameter int MAX_VEL    = 3,
    parameter int ACCEL_STEP = 1,
    parameter int DECEL_STEP = 1,
    parameter int TICK_DIV   = 250000,
    parameter int DB_CYCLES  = 65536
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    btn_up,
    input  logic                    btn_down,
    input  logic                    btn_left,
    input  logic                    btn_right,
    input  logic                    mode_snap,
    input  logic                    hold,
    input  logic                    force_en,
    output logic signed [VEL_W-1:0] x_vel,
    output logic signed [VEL_W-1:0] y_vel,
    output logic [3:0]              btn_stable,
    output logic [3:0]              btn_press,
    output logic                    tick,
    output logic                    dir_enable
);

    localparam int EXT_W = VEL_W + 1;
    localparam int DB_W  = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int TK_W  = $clog2(TICK_DIV);

    localparam logic [DB_W-1:0]         c_db_last = DB_W'(DB_CYCLES - 1);
    localparam logic [TK_W-1:0]         c_tk_last = TK_W'(TICK_DIV - 1);
    localparam logic signed [EXT_W-1:0] c_vmax    = EXT_W'(MAX_VEL);
    localparam logic signed [EXT_W-1:0] c_accel   = EXT_W'(ACCEL_STEP);
    localparam logic signed [EXT_W-1:0] c_decel   = EXT_W'(DECEL_STEP);
    localparam logic signed [EXT_W-1:0] c_zero    = '0;

    // Button bit order everywhere: {up, down, left, right}
    logic [3:0]            w_raw;
    logic [3:0]            sync1_q;
    logic [3:0]            sync2_q;
    logic [3:0]            stable_q;
    logic [3:0]            stable_d;
    logic [3:0]            stable_dly_q;
    logic [3:0]            press_q;
    logic [3:0][DB_W-1:0]  db_cnt_q;
    logic [3:0][DB_W-1:0]  db_cnt_d;
    logic [TK_W-1:0]       tick_cnt_q;
    logic [TK_W-1:0]       tick_cnt_d;
    logic                  tick_q;
    logic                  tick_d;
    logic signed [VEL_W-1:0] x_vel_q;
    logic signed [VEL_W-1:0] x_vel_d;
    logic signed [VEL_W-1:0] y_vel_q;
    logic signed [VEL_W-1:0] y_vel_d;

    assign w_raw = {btn_up, btn_down, btn_left, btn_right};

    // A button's stable level flips only after DB_CYCLES consecutive disagreeing samples
    always_comb begin
        stable_d = stable_q;
        db_cnt_d = db_cnt_q;
        for (int i = 0; i < 4; i++) begin
            if (sync2_q[i] == stable_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (db_cnt_q[i] == c_db_last) begin
                stable_d[i] = sync2_q[i];
                db_cnt_d[i] = '0;
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
            end
        end
    end

    always_comb begin
        tick_d     = (tick_cnt_q == c_tk_last);
        tick_cnt_d = tick_d ? '0 : tick_cnt_q + TK_W'(1);
    end

    // Next velocity for one axis; computed one bit wider so the clamp never sees a wrap
    function automatic logic signed [VEL_W-1:0] f_next_vel(
        input logic signed [VEL_W-1:0] v,
        input logic                    neg,
        input logic                    pos,
        input logic                    snap
    );
        logic signed [EXT_W-1:0] e;
        logic signed [EXT_W-1:0] r;
        e = {v[VEL_W-1], v};
        r = e;
        if (neg && !pos) begin
            if (snap) begin
                r = -c_vmax;
            end else begin
                r = e - c_accel;
                if (r < -c_vmax) r = -c_vmax;
            end
        end else if (pos && !neg) begin
            if (snap) begin
                r = c_vmax;
            end else begin
                r = e + c_accel;
                if (r > c_vmax) r = c_vmax;
            end
        end else if (snap) begin
            r = c_zero;
        end else if (e > c_zero) begin
            r = (e > c_decel) ? (e - c_decel) : c_zero;
        end else if (e < c_zero) begin
            r = (e < -c_decel) ? (e + c_decel) : c_zero;
        end
        return r[VEL_W-1:0];
    endfunction

    always_comb begin
        x_vel_d = x_vel_q;
        y_vel_d = y_vel_q;
        if (tick_q && !hold) begin
            x_vel_d = f_next_vel(x_vel_q, stable_q[1], stable_q[0], mode_snap);
            y_vel_d = f_next_vel(y_vel_q, stable_q[3], stable_q[2], mode_snap);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            stable_q     <= '0;
            stable_dly_q <= '0;
            press_q      <= '0;
            db_cnt_q     <= '0;
            tick_cnt_q   <= '0;
            tick_q       <= 1'b0;
            x_vel_q      <= '0;
            y_vel_q      <= '0;
        end else begin
            sync1_q      <= w_raw;
            sync2_q      <= sync1_q;
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            press_q      <= stable_q & ~stable_dly_q;
            db_cnt_q     <= db_cnt_d;
            tick_cnt_q   <= tick_cnt_d;
            tick_q       <= tick_d;
            x_vel_q      <= x_vel_d;
            y_vel_q      <= y_vel_d;
        end
    end

    assign x_vel      = x_vel_q;
    assign y_vel      = y_vel_q;
    assign btn_stable = stable_q;
    assign btn_press  = press_q;
    assign tick       = tick_q;
    assign dir_enable = force_en | (|stable_q);

endmodule
`default_nettype wire

// File: tb/tb_velocity_ramp_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_velocity_ramp_ctrl
// Description : Table-driven self-checking bench for velocity_ramp_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_velocity_ramp_ctrl;

    localparam int VEL_W = 13;

    logic clk;
    logic rst;
    logic btn_up, btn_down, btn_left, btn_right;
    logic mode_snap, hold, force_en;

    logic signed [VEL_W-1:0] x_vel, y_vel, x_vel2, y_vel2;
    logic [3:0] btn_stable, btn_press, btn_stable2, btn_press2;
    logic tick, dir_enable, tick2, dir_enable2;

    int n_checks = 0;
    int n_fail   = 0;

    velocity_ramp_ctrl #(
        .VEL_W(VEL_W), .MAX_VEL(3), .ACCEL_STEP(1), .DECEL_STEP(1),
        .TICK_DIV(4), .DB_CYCLES(3)
    ) dut (
        .clk(clk), .rst(rst),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .mode_snap(mode_snap), .hold(hold), .force_en(force_en),
        .x_vel(x_vel), .y_vel(y_vel), .btn_stable(btn_stable), .btn_press(btn_press),
        .tick(tick), .dir_enable(dir_enable)
    );

    velocity_ramp_ctrl #(
        .VEL_W(VEL_W), .MAX_VEL(3), .ACCEL_STEP(1), .DECEL_STEP(2),
        .TICK_DIV(4), .DB_CYCLES(3)
    ) dut2 (
        .clk(clk), .rst(rst),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .mode_snap(mode_snap), .hold(hold), .force_en(force_en),
        .x_vel(x_vel2), .y_vel(y_vel2), .btn_stable(btn_stable2), .btn_press(btn_press2),
        .tick(tick2), .dir_enable(dir_enable2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [3:0] btn;
        logic       snap;
        logic       hold;
        int         n;
        logic [3:0] stable;
        logic [3:0] press;
        logic       tick;
        logic       dir;
        int         x;
        int         y;
        int         x2;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic [3:0] b, input logic s, input logic h, input int n,
                       input logic [3:0] st, input logic [3:0] pr, input logic tk,
                       input logic de, input int x, input int y, input int x2);
        vec_t v;
        v.btn = b; v.snap = s; v.hold = h; v.n = n;
        v.stable = st; v.press = pr; v.tick = tk; v.dir = de;
        v.x = x; v.y = y; v.x2 = x2;
        vq.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, got, exp);
        end
    endtask

    // Drive one record at a negedge, advance n posedges, compare at the following negedge
    task automatic run_vec(input vec_t v, input int idx);
        {btn_up, btn_down, btn_left, btn_right} = v.btn;
        mode_snap = v.snap;
        hold      = v.hold;
        repeat (v.n) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (btn_stable !== v.stable || btn_press !== v.press || tick !== v.tick ||
            dir_enable !== v.dir || x_vel !== VEL_W'(v.x) || y_vel !== VEL_W'(v.y) ||
            x_vel2 !== VEL_W'(v.x2)) begin
            n_fail++;
            $display("FAIL vec%0d: got stable=%b press=%b tick=%b dir=%b x=%0d y=%0d x2=%0d, want stable=%b press=%b tick=%b dir=%b x=%0d y=%0d x2=%0d",
                     idx, btn_stable, btn_press, tick, dir_enable, x_vel, y_vel, x_vel2,
                     v.stable, v.press, v.tick, v.dir, v.x, v.y, v.x2);
        end
    endtask

    initial begin
        int split;
        rst = 1'b1;
        {btn_up, btn_down, btn_left, btn_right} = 4'b0000;
        mode_snap = 1'b0; hold = 1'b0; force_en = 1'b0;

        // Phase 1 (ramp): right held from release, release, glitch, both-held cancel
        add(4'b0001,0,0,4, 4'b0000,4'b0000,1,0, 0,0,0);
        add(4'b0001,0,0,1, 4'b0001,4'b0000,0,1, 0,0,0);
        add(4'b0001,0,0,1, 4'b0001,4'b0001,0,1, 0,0,0);
        add(4'b0001,0,0,1, 4'b0001,4'b0000,0,1, 0,0,0);
        add(4'b0001,0,0,1, 4'b0001,4'b0000,1,1, 0,0,0);
        add(4'b0001,0,0,1, 4'b0001,4'b0000,0,1, 1,0,1);
        add(4'b0001,0,0,4, 4'b0001,4'b0000,0,1, 2,0,2);
        add(4'b0001,0,0,4, 4'b0001,4'b0000,0,1, 3,0,3);
        add(4'b0001,0,0,4, 4'b0001,4'b0000,0,1, 3,0,3);
        add(4'b0000,0,0,5, 4'b0000,4'b0000,0,0, 3,0,3);
        add(4'b0000,0,0,3, 4'b0000,4'b0000,0,0, 2,0,1);
        add(4'b0000,0,0,4, 4'b0000,4'b0000,0,0, 1,0,0);
        add(4'b0000,0,0,4, 4'b0000,4'b0000,0,0, 0,0,0);
        add(4'b0000,0,0,4, 4'b0000,4'b0000,0,0, 0,0,0);
        add(4'b1000,0,0,2, 4'b0000,4'b0000,0,0, 0,0,0);
        add(4'b0000,0,0,1, 4'b0000,4'b0000,1,0, 0,0,0);
        add(4'b0000,0,0,1, 4'b0000,4'b0000,0,0, 0,0,0);
        add(4'b0000,0,0,1, 4'b0000,4'b0000,0,0, 0,0,0);
        add(4'b0000,0,0,1, 4'b0000,4'b0000,0,0, 0,0,0);
        add(4'b0001,0,0,5, 4'b0001,4'b0000,1,1, 0,0,0);
        add(4'b0001,0,0,1, 4'b0001,4'b0001,0,1, 1,0,1);
        add(4'b0001,0,0,2, 4'b0001,4'b0000,0,1, 1,0,1);
        add(4'b0011,0,0,2, 4'b0001,4'b0000,0,1, 2,0,2);
        add(4'b0011,0,0,3, 4'b0011,4'b0000,1,1, 2,0,2);
        add(4'b0011,0,0,1, 4'b0011,4'b0010,0,1, 1,0,0);
        add(4'b0011,0,0,4, 4'b0011,4'b0000,0,1, 0,0,0);
        add(4'b0011,0,0,4, 4'b0011,4'b0000,0,1, 0,0,0);
        add(4'b0001,0,0,4, 4'b0011,4'b0000,0,1, 0,0,0);
        add(4'b0001,0,0,1, 4'b0001,4'b0000,0,1, 0,0,0);
        add(4'b0001,0,0,3, 4'b0001,4'b0000,0,1, 1,0,1);
        add(4'b0001,0,0,4, 4'b0001,4'b0000,0,1, 2,0,2);
        add(4'b0001,0,0,3, 4'b0001,4'b0000,1,1, 2,0,2);
        split = vq.size();

        // Phase 2 (after mid-ramp reset): snap, hold, snap to negative, ramp reversal
        add(4'b0100,1,0,5, 4'b0100,4'b0000,0,1, 0,0,0);
        add(4'b0100,1,0,1, 4'b0100,4'b0100,0,1, 0,0,0);
        add(4'b0100,1,0,2, 4'b0100,4'b0000,1,1, 0,0,0);
        add(4'b0100,1,0,1, 4'b0100,4'b0000,0,1, 0,3,0);
        add(4'b0000,1,0,4, 4'b0100,4'b0000,0,1, 0,3,0);
        add(4'b0000,1,0,4, 4'b0000,4'b0000,0,0, 0,0,0);
        add(4'b0100,1,1,8, 4'b0100,4'b0000,0,1, 0,0,0);
        add(4'b0100,1,1,4, 4'b0100,4'b0000,0,1, 0,0,0);
        add(4'b0100,1,0,4, 4'b0100,4'b0000,0,1, 0,3,0);
        add(4'b1000,1,0,5, 4'b1000,4'b0000,0,1, 0,3,0);
        add(4'b1000,1,0,3, 4'b1000,4'b0000,0,1, 0,-3,0);
        add(4'b1000,0,0,4, 4'b1000,4'b0000,0,1, 0,-3,0);
        add(4'b0100,0,0,8, 4'b0100,4'b0000,0,1, 0,-2,0);
        add(4'b0100,0,0,4, 4'b0100,4'b0000,0,1, 0,-1,0);
        add(4'b0100,0,1,8, 4'b0100,4'b0000,0,1, 0,-1,0);
        add(4'b0100,0,0,4, 4'b0100,4'b0000,0,1, 0,0,0);
        add(4'b0100,0,0,4, 4'b0100,4'b0000,0,1, 0,1,0);

        repeat (2) @(negedge clk);
        check("reset_state", {12'd0, btn_stable, btn_press, tick, dir_enable, 1'b0, x_vel},
              32'd0);
        check("reset_y", {19'd0, y_vel}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < split; i++) run_vec(vq[i], i);

        // Asynchronous reset between edges while x_vel=2 and tick is high
        rst = 1'b1;
        {btn_up, btn_down, btn_left, btn_right} = 4'b0000;
        #1;
        check("async_rst_x", {19'd0, x_vel}, 32'd0);
        check("async_rst_tick", {31'd0, tick}, 32'd0);
        check("async_rst_stable", {28'd0, btn_stable}, 32'd0);
        #1;
        rst = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("first_tick_c%0d", k), {31'd0, tick}, (k == 4) ? 32'd1 : 32'd0);
        end
        force_en = 1'b1;
        #1;
        check("force_en_dir", {31'd0, dir_enable}, 32'd1);
        force_en = 1'b0;
        #1;
        check("no_force_dir", {31'd0, dir_enable}, 32'd0);

        for (int i = split; i < vq.size(); i++) run_vec(vq[i], i);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
